// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: flushes denormals, restoring division one
// quotient bit per cycle, round-to-nearest-even, IEEE-style special handling.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [3:0]   flags
);

  localparam int QW = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_CALC, S_ROUND, S_DONE} state_t;

  state_t state, state_nxt;

  logic               sgn;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic [QW-1:0]      rem, q, mbx, rem_sub;
  logic [CW-1:0]      cnt;
  logic               ge, accept, spec_in;
  logic [EXP_W-1:0]   a_exp, b_exp;

  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [QW-1:0]      norm;
  logic [MAN_W:0]     man;
  logic               g_bit, r_bit, s_bit, inc;
  logic [MAN_W+1:0]   sum;
  logic [MAN_W-1:0]   frac_r;
  logic [EW-1:0]      e_pre, e_fin;
  logic [W-1:0]       res_out;
  logic [3:0]         res_flags;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;

  assign a_exp   = a[W-2:MAN_W];
  assign b_exp   = b[W-2:MAN_W];
  assign spec_in = (a_exp == '0) | (&a_exp) | (b_exp == '0) | (&b_exp);

  assign mbx     = {2'b00, 1'b1, fb};
  assign ge      = (rem >= mbx);
  assign rem_sub = ge ? (rem - mbx) : rem;

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // A quotient below 1.0 leaves the MSB clear; the lost round bit is covered by sticky.
  assign norm   = q[QW-1] ? q : (q << 1);
  assign man    = norm[QW-1:2];
  assign g_bit  = norm[1];
  assign r_bit  = norm[0];
  assign s_bit  = (rem != '0);
  assign inc    = g_bit & (r_bit | s_bit | man[0]);
  assign sum    = {1'b0, man} + {{(MAN_W + 1){1'b0}}, inc};
  assign frac_r = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign e_pre  = {2'b00, ea} - {2'b00, eb} + BIAS - {{(EW - 1){1'b0}}, ~q[QW-1]};
  assign e_fin  = e_pre + {{(EW - 1){1'b0}}, sum[MAN_W+1]};

  always_comb begin
    res_out   = '0;
    res_flags = '0;
    if (state == S_SPECIAL) begin
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
        res_out   = QNAN;
        res_flags = 4'b1000;
      end else if (a_inf) begin
        res_out = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
        res_out = {sgn, {(W - 1){1'b0}}};
      end else if (b_zero) begin
        res_out   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res_flags = 4'b0100;
      end else begin
        res_out = {sgn, {(W - 1){1'b0}}};
      end
    end else if ($signed(e_fin) >= $signed(EMAX)) begin
      res_out   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 4'b0010;
    end else if ($signed(e_fin) <= 0) begin
      res_out   = {sgn, {(W - 1){1'b0}}};
      res_flags = 4'b0001;
    end else begin
      res_out = {sgn, e_fin[EXP_W-1:0], frac_r};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = spec_in ? S_SPECIAL : S_CALC;
      S_SPECIAL: state_nxt = S_DONE;
      S_CALC:    if (cnt == '0) state_nxt = S_ROUND;
      S_ROUND:   state_nxt = S_DONE;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn   <= 1'b0;
      ea    <= '0;
      eb    <= '0;
      fa    <= '0;
      fb    <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
      out   <= '0;
      flags <= '0;
    end else begin
      if (accept) begin
        sgn <= a[W-1] ^ b[W-1];
        ea  <= a_exp;
        eb  <= b_exp;
        fa  <= a[MAN_W-1:0];
        fb  <= b[MAN_W-1:0];
        rem <= {3'b001, a[MAN_W-1:0]};
        q   <= '0;
        cnt <= CW'(QW - 1);
      end
      if (state == S_CALC) begin
        q   <= {q[QW-2:0], ge};
        rem <= rem_sub << 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (state == S_SPECIAL || state == S_ROUND) begin
        out   <= res_out;
        flags <= res_flags;
      end
    end
  end

endmodule
